// File: rtl/register_reader_pkg.sv
// Shared types and sizing helpers for the register reader slice.
package register_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} reader_state_t;

  // bits_left must hold the full word length, hence the extra bit.
  function automatic int cnt_width(input int bit_count);
    return $clog2(bit_count) + 1;
  endfunction
endpackage

// File: rtl/register_reader_down_counter.sv
// Loadable down counter with decrement enable and zero flag; holds at zero.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/register_reader.sv
// Parallel-in, serial-out word reader with valid/ready on both sides and a done pulse.
module register_reader
  import register_pkg::*;
#(
  parameter int BIT_COUNT = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [BIT_COUNT-1:0]              data,
  input  logic                              load_valid,
  output logic                              load_ready,
  output logic                              serial_out,
  output logic                              serial_valid,
  input  logic                              serial_ready,
  output logic [cnt_width(BIT_COUNT)-1:0]   bits_left,
  output logic                              done
);
  localparam int CW = cnt_width(BIT_COUNT);
  localparam logic [CW-1:0] FULL = CW'(BIT_COUNT);
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  reader_state_t        state;
  logic [BIT_COUNT-1:0] shreg;
  logic                 accept;
  logic                 xfer;
  logic                 empty;

  assign accept = (state == IDLE) && load_valid;
  assign xfer   = (state == SHIFT) && serial_ready;

  down_counter #(.WIDTH(CW)) u_bits_left (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .value   (FULL),
    .dec     (xfer),
    .count   (bits_left),
    .zero    (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shreg <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= data;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (serial_ready) begin
            shreg <= (MSB_FIRST != 0) ? {shreg[BIT_COUNT-2:0], 1'b0}
                                      : {1'b0, shreg[BIT_COUNT-1:1]};
            if (bits_left == ONE) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else if (empty) begin
            // Unreachable in normal operation; never strand the FSM in SHIFT.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load_ready   = (state == IDLE);
  assign serial_valid = (state == SHIFT);
  assign serial_out   = (MSB_FIRST != 0) ? shreg[BIT_COUNT-1] : shreg[0];
endmodule

// File: tb/tb_register_reader.sv
// Directed bench for register_reader: LSB- and MSB-first instances driven in parallel.
module tb_register_reader;
  localparam int BC = 8;
  localparam int CW = $clog2(BC) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [BC-1:0] data = '0;
  logic          load_valid = 1'b0;
  logic          serial_ready = 1'b0;

  logic          lr0, so0, sv0, dn0;
  logic [CW-1:0] bl0;
  logic          lr1, so1, sv1, dn1;
  logic [CW-1:0] bl1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  register_reader #(.BIT_COUNT(BC), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .data(data), .load_valid(load_valid),
    .load_ready(lr0), .serial_out(so0), .serial_valid(sv0),
    .serial_ready(serial_ready), .bits_left(bl0), .done(dn0)
  );

  register_reader #(.BIT_COUNT(BC), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .data(data), .load_valid(load_valid),
    .load_ready(lr1), .serial_out(so1), .serial_valid(sv1),
    .serial_ready(serial_ready), .bits_left(bl1), .done(dn1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads a whole word out of the LSB-first instance with serial_ready high,
  // then checks the done cycle and the cycle after it.
  task automatic read_word(input string tag, input logic [BC-1:0] word);
    for (int i = 0; i < BC; i++) begin
      check({tag, "_bit"}, 32'(so0), 32'(word[i]));
      check({tag, "_left"}, 32'(bl0), 32'(BC - i));
      check({tag, "_nodone"}, 32'(dn0), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(dn0), 32'd1);
    check({tag, "_done_lr"}, 32'(lr0), 32'd1);
    check({tag, "_idle_left"}, 32'(bl0), 32'd0);
    tick();
    check({tag, "_done_gone"}, 32'(dn0), 32'd0);
  endtask

  initial begin
    logic [BC-1:0] w;

    // Asynchronous reset before any clock edge
    #2 reset_n = 1'b0;
    #1;
    check("rst_lr", 32'(lr0), 32'd1);
    check("rst_sv", 32'(sv0), 32'd0);
    check("rst_so", 32'(so0), 32'd0);
    check("rst_done", 32'(dn0), 32'd0);
    check("rst_left", 32'(bl0), 32'd0);
    check("rst_msb_so", 32'(so1), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // LSB-first and MSB-first readout of C4, ready held high
    w = 8'hC4;
    data = w;
    load_valid = 1'b1;
    serial_ready = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < BC; i++) begin
      check("lsb_bit", 32'(so0), 32'(w[i]));
      check("msb_bit", 32'(so1), 32'(w[BC-1-i]));
      check("lsb_left", 32'(bl0), 32'(BC - i));
      check("lsb_sv", 32'(sv0), 32'd1);
      check("lsb_lr", 32'(lr0), 32'd0);
      check("lsb_nodone", 32'(dn0), 32'd0);
      tick();
    end
    check("lsb_done", 32'(dn0), 32'd1);
    check("msb_done", 32'(dn1), 32'd1);
    check("lsb_done_lr", 32'(lr0), 32'd1);
    check("lsb_done_sv", 32'(sv0), 32'd0);
    tick();
    check("lsb_done_once", 32'(dn0), 32'd0);

    // Backpressure: stall 3 cycles after two bits accepted
    data = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("bp_bit", 32'(so0), 32'(w[i]));
      tick();
    end
    serial_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("bp_hold_bit", 32'(so0), 32'(w[2]));
      check("bp_hold_left", 32'(bl0), 32'd6);
      check("bp_hold_sv", 32'(sv0), 32'd1);
      tick();
    end
    serial_ready = 1'b1;
    for (int i = 2; i < BC; i++) begin
      check("bp_bit", 32'(so0), 32'(w[i]));
      check("bp_left", 32'(bl0), 32'(BC - i));
      check("bp_nodone", 32'(dn0), 32'd0);
      tick();
    end
    check("bp_done", 32'(dn0), 32'd1);
    tick();

    // Back-to-back: load_valid stays high, ignored mid-shift, taken in done cycle
    data = 8'h01;
    load_valid = 1'b1;
    tick();
    data = 8'hFF;
    for (int i = 0; i < BC; i++) begin
      check("b2b_first_bit", 32'(so0), (i == 0) ? 32'd1 : 32'd0);
      check("b2b_first_left", 32'(bl0), 32'(BC - i));
      tick();
    end
    check("b2b_done", 32'(dn0), 32'd1);
    check("b2b_done_lr", 32'(lr0), 32'd1);
    tick();
    load_valid = 1'b0;
    check("b2b_no_gap_sv", 32'(sv0), 32'd1);
    read_word("b2b_second", 8'hFF);

    // Abort mid-word with bits_left = 4
    data = 8'hC4;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_pre_left", 32'(bl0), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    check("abort_lr", 32'(lr0), 32'd1);
    check("abort_sv", 32'(sv0), 32'd0);
    check("abort_so", 32'(so0), 32'd0);
    check("abort_left", 32'(bl0), 32'd0);
    check("abort_done", 32'(dn0), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("abort_no_done", 32'(dn0), 32'd0);
      check("abort_idle_lr", 32'(lr0), 32'd1);
      tick();
    end
    data = 8'hA0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    read_word("after_abort", 8'hA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
